// File: rtl/cpu_types.sv
// Shared CPU types: load/store FSM states, memory-size funct3 encodings, access legality check.
package cpu_types;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Unsigned sizes only make sense for loads; halves need even, words 4-byte alignment.
   function automatic logic lsu_legal(input logic is_store, input logic [2:0] f3,
                                      input logic [1:0] off);
      logic ok;
      case (f3)
         F3_B:    ok = 1'b1;
         F3_H:    ok = ~off[0];
         F3_W:    ok = (off == 2'b00);
         F3_BU:   ok = ~is_store;
         F3_HU:   ok = ~is_store & ~off[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: store strobes/replication and load lane extract/extend.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module lsu_align #(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       funct3,
   input  logic [1:0]       offset,
   input  logic [WIDTH-1:0] wdata,
   input  logic [WIDTH-1:0] word,
   output logic [3:0]       wstrb,
   output logic [WIDTH-1:0] wdata_rep,
   output logic [WIDTH-1:0] rdata_ext
);
   import cpu_types::*;

   logic [WIDTH-1:0] shifted;
   logic [7:0]       lane_b;
   logic [15:0]      lane_h;

   always_comb begin
      shifted = word >> {offset, 3'b000};
      lane_b  = shifted[7:0];
      lane_h  = shifted[15:0];

      // funct3[1:0] alone gives the size; the sign bit only matters for loads.
      case (funct3[1:0])
         2'b00: begin
            wstrb     = 4'b0001 << offset;
            wdata_rep = {(WIDTH/8){wdata[7:0]}};
         end
         2'b01: begin
            wstrb     = 4'b0011 << offset;
            wdata_rep = {(WIDTH/16){wdata[15:0]}};
         end
         default: begin
            wstrb     = 4'b1111;
            wdata_rep = wdata;
         end
      endcase

      case (funct3)
         F3_B:    rdata_ext = {{(WIDTH-8){lane_b[7]}}, lane_b};
         F3_BU:   rdata_ext = {{(WIDTH-8){1'b0}}, lane_b};
         F3_H:    rdata_ext = {{(WIDTH-16){lane_h[15]}}, lane_h};
         F3_HU:   rdata_ext = {{(WIDTH-16){1'b0}}, lane_h};
         default: rdata_ext = shifted;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns core byte/half/word accesses into aligned word bus transfers.
// Latency: 2 stall cycles (IDLE, REQ) plus the DONE commit cycle when bus_ready/bus_rvalid are immediate.
// Backpressure: holds bus_valid and payload stable until bus_ready; stalls the core until DONE.
module load_store_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req,
   input  logic             we,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             stall,
   output logic             fault,
   output logic             bus_valid,
   input  logic             bus_ready,
   output logic             bus_we,
   output logic [WIDTH-1:0] bus_addr,
   output logic [WIDTH-1:0] bus_wdata,
   output logic [3:0]       bus_wstrb,
   input  logic             bus_rvalid,
   input  logic [WIDTH-1:0] bus_rdata
);
   import cpu_types::*;

   lsu_state_t       state, state_nxt;
   logic             we_q;
   logic [2:0]       funct3_q;
   logic [WIDTH-1:0] addr_q, wdata_q, rdata_q;
   logic             capture, load_commit, fault_c, in_req;
   logic [3:0]       strb;
   logic [WIDTH-1:0] wrep, ext;

   lsu_align #(.WIDTH(WIDTH)) u_align (
      .funct3    (funct3_q),
      .offset    (addr_q[1:0]),
      .wdata     (wdata_q),
      .word      (bus_rdata),
      .wstrb     (strb),
      .wdata_rep (wrep),
      .rdata_ext (ext)
   );

   always_comb begin
      state_nxt   = state;
      capture     = 1'b0;
      load_commit = 1'b0;
      fault_c     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req) begin
               if (lsu_legal(we, funct3, addr[1:0])) begin
                  capture   = 1'b1;
                  state_nxt = ST_REQ;
               end else begin
                  fault_c = rst_n;
               end
            end
         end
         ST_REQ: begin
            if (bus_ready) begin
               if (we_q) begin
                  state_nxt = ST_DONE;
               end else if (bus_rvalid) begin
                  load_commit = 1'b1;
                  state_nxt   = ST_DONE;
               end else begin
                  state_nxt = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            if (bus_rvalid) begin
               load_commit = 1'b1;
               state_nxt   = ST_DONE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         we_q     <= 1'b0;
         funct3_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            we_q     <= we;
            funct3_q <= funct3;
            addr_q   <= addr;
            wdata_q  <= wdata;
            rdata_q  <= '0;
         end
         if (load_commit) rdata_q <= ext;
      end
   end

   // Bus payload is only driven while a request is outstanding, so idle and reset read as zero.
   assign in_req    = (state == ST_REQ);
   assign bus_valid = in_req;
   assign bus_we    = in_req & we_q;
   assign bus_addr  = in_req ? {addr_q[WIDTH-1:2], 2'b00} : '0;
   assign bus_wdata = (in_req && we_q) ? wrep : '0;
   assign bus_wstrb = (in_req && we_q) ? strb : 4'b0000;

   assign rdata = (state == ST_DONE) ? rdata_q : '0;
   assign fault = fault_c;
   assign stall = rst_n & req & (state != ST_DONE) & ~fault_c;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of accesses plus reset corner sequences.
module tb_load_store_unit;
   import cpu_types::*;

   logic        clk = 1'b0;
   logic        rst_n, req, we, bus_ready, bus_rvalid;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata, bus_rdata;
   logic [31:0] rdata, bus_addr, bus_wdata;
   logic        stall, fault, bus_valid, bus_we;
   logic [3:0]  bus_wstrb;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   load_store_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .funct3(funct3), .addr(addr),
      .wdata(wdata), .rdata(rdata), .stall(stall), .fault(fault),
      .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
      .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
   );

   typedef struct {
      logic        w;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rw;
      int          rdy;
      int          rv;
      logic        xfault;
      logic [31:0] xaddr;
      logic [3:0]  xstrb;
      logic [31:0] xwdata;
      logic [31:0] xrdata;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs[NV];

   int          o_stall, o_fault;
   logic        o_vld, o_stable, o_done, o_we;
   logic [31:0] o_addr, o_wdata, o_rdata;
   logic [3:0]  o_strb;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Runs one access starting just after a negedge; acts as the bus slave with the given delays.
   task automatic access(input vec_t v);
      int hs_cyc;
      int rdy_cnt;
      req = 1'b1; we = v.w; funct3 = v.f3; addr = v.a; wdata = v.wd; bus_rdata = v.rw;
      o_stall = 0; o_fault = 0; o_vld = 1'b0; o_stable = 1'b1; o_done = 1'b0; o_we = 1'b0;
      o_addr = '0; o_wdata = '0; o_strb = '0; o_rdata = '1;
      hs_cyc = -1; rdy_cnt = 0;
      for (int cyc = 0; cyc < 60 && !o_done; cyc++) begin
         bus_ready  = bus_valid && (rdy_cnt >= v.rdy);
         bus_rvalid = !v.w && ((bus_ready && v.rv == 0) ||
                               (hs_cyc >= 0 && v.rv > 0 && cyc - hs_cyc == v.rv));
         #1;
         if (stall) o_stall++;
         if (fault) o_fault++;
         if (bus_valid) begin
            if (!o_vld) begin
               o_addr = bus_addr; o_strb = bus_wstrb; o_wdata = bus_wdata; o_we = bus_we;
            end else if (bus_addr !== o_addr || bus_wstrb !== o_strb ||
                         bus_wdata !== o_wdata || bus_we !== o_we) begin
               o_stable = 1'b0;
            end
            o_vld = 1'b1;
            if (bus_ready) hs_cyc = cyc;
            else rdy_cnt++;
         end
         if (!stall) begin
            o_done  = 1'b1;
            o_rdata = rdata;
         end
         @(negedge clk);
      end
      req = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //              w     f3     addr       wdata         rword         rdy rv flt  xaddr      xstrb   xwdata        xrdata
      vecs[0]  = '{1'b1, F3_W,  32'h104, 32'hDEADBEEF, 32'h0,         0, 0, 1'b0, 32'h104, 4'b1111, 32'hDEADBEEF, 32'h0};
      vecs[1]  = '{1'b0, F3_B,  32'h203, 32'h0,        32'h80FF0011,  0, 3, 1'b0, 32'h200, 4'b0000, 32'h0,        32'hFFFFFF80};
      vecs[2]  = '{1'b0, F3_BU, 32'h203, 32'h0,        32'h80FF0011,  0, 3, 1'b0, 32'h200, 4'b0000, 32'h0,        32'h00000080};
      vecs[3]  = '{1'b1, F3_H,  32'h12,  32'h0000ABCD, 32'h0,         0, 0, 1'b0, 32'h10,  4'b1100, 32'hABCDABCD, 32'h0};
      vecs[4]  = '{1'b0, F3_W,  32'h102, 32'h0,        32'h0,         0, 0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
      vecs[5]  = '{1'b1, F3_W,  32'h40,  32'h11223344, 32'h0,         5, 0, 1'b0, 32'h40,  4'b1111, 32'h11223344, 32'h0};
      vecs[6]  = '{1'b0, F3_H,  32'h202, 32'h0,        32'h80FF0011,  0, 0, 1'b0, 32'h200, 4'b0000, 32'h0,        32'hFFFF80FF};
      vecs[7]  = '{1'b0, F3_HU, 32'h202, 32'h0,        32'h80FF0011,  1, 2, 1'b0, 32'h200, 4'b0000, 32'h0,        32'h000080FF};
      vecs[8]  = '{1'b0, F3_H,  32'h200, 32'h0,        32'h80FF0011,  0, 1, 1'b0, 32'h200, 4'b0000, 32'h0,        32'h00000011};
      vecs[9]  = '{1'b0, F3_B,  32'h202, 32'h0,        32'h80FF0011,  2, 0, 1'b0, 32'h200, 4'b0000, 32'h0,        32'hFFFFFFFF};
      vecs[10] = '{1'b1, F3_B,  32'h7,   32'h0000005A, 32'h0,         0, 0, 1'b0, 32'h4,   4'b1000, 32'h5A5A5A5A, 32'h0};
      vecs[11] = '{1'b1, F3_H,  32'h13,  32'h0000ABCD, 32'h0,         0, 0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
      vecs[12] = '{1'b0, 3'b011,32'h100, 32'h0,        32'h0,         0, 0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
      vecs[13] = '{1'b1, F3_BU, 32'h0,   32'h000000FF, 32'h0,         0, 0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
      vecs[14] = '{1'b0, F3_W,  32'h300, 32'h0,        32'h12345678,  0, 2, 1'b0, 32'h300, 4'b0000, 32'h0,        32'h12345678};
      vecs[15] = '{1'b0, F3_HU, 32'h201, 32'h0,        32'h0,         0, 0, 1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};

      // Reset with a pending request and an illegal size: everything quiet.
      rst_n = 1'b0; req = 1'b1; we = 1'b0; funct3 = F3_W; addr = 32'h100; wdata = '0;
      bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'hFFFFFFFF;
      repeat (3) @(negedge clk);
      #1;
      chk("rst stall", {31'd0, stall}, 32'd0);
      chk("rst rdata", rdata, 32'h0);
      chk("rst bus_valid", {31'd0, bus_valid}, 32'd0);
      chk("rst bus_we", {31'd0, bus_we}, 32'd0);
      chk("rst bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
      chk("rst bus_addr", bus_addr, 32'h0);
      chk("rst bus_wdata", bus_wdata, 32'h0);
      funct3 = 3'b111;
      #1;
      chk("rst fault", {31'd0, fault}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1; req = 1'b0;
      #1;
      chk("idle no req stall", {31'd0, stall}, 32'd0);
      chk("idle no req bus_valid", {31'd0, bus_valid}, 32'd0);
      @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         access(vecs[i]);
         chk($sformatf("v%0d done", i), {31'd0, o_done}, 32'd1);
         chk($sformatf("v%0d fault", i), o_fault, {31'd0, vecs[i].xfault});
         chk($sformatf("v%0d stall cycles", i), o_stall,
             vecs[i].xfault ? 0 : 2 + vecs[i].rdy + (vecs[i].w ? 0 : vecs[i].rv));
         chk($sformatf("v%0d rdata", i), o_rdata, vecs[i].xrdata);
         if (vecs[i].xfault) begin
            chk($sformatf("v%0d no bus", i), {31'd0, o_vld}, 32'd0);
         end else begin
            chk($sformatf("v%0d bus_addr", i), o_addr, vecs[i].xaddr);
            chk($sformatf("v%0d bus_wstrb", i), {28'd0, o_strb}, {28'd0, vecs[i].xstrb});
            chk($sformatf("v%0d bus_we", i), {31'd0, o_we}, {31'd0, vecs[i].w});
            chk($sformatf("v%0d stable", i), {31'd0, o_stable}, 32'd1);
            if (vecs[i].w) chk($sformatf("v%0d bus_wdata", i), o_wdata, vecs[i].xwdata);
         end
         #1;
         chk($sformatf("v%0d after stall", i), {31'd0, stall}, 32'd0);
         chk($sformatf("v%0d after fault", i), {31'd0, fault}, 32'd0);
         chk($sformatf("v%0d after bus_valid", i), {31'd0, bus_valid}, 32'd0);
         @(negedge clk);
      end

      // Reset while waiting in RESP, then a stale rvalid must not produce a commit.
      req = 1'b1; we = 1'b0; funct3 = F3_W; addr = 32'h100; bus_rdata = 32'hCAFEF00D;
      #1;
      chk("mid idle stall", {31'd0, stall}, 32'd1);
      @(negedge clk);
      bus_ready = 1'b1;
      #1;
      chk("mid req bus_valid", {31'd0, bus_valid}, 32'd1);
      @(negedge clk);
      bus_ready = 1'b0;
      #1;
      chk("mid resp stall", {31'd0, stall}, 32'd1);
      chk("mid resp bus_valid", {31'd0, bus_valid}, 32'd0);
      chk("mid resp state", {30'd0, dut.state}, {30'd0, ST_RESP});
      rst_n = 1'b0;
      #1;
      chk("mid rst stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1; req = 1'b0; bus_rvalid = 1'b1;
      #1;
      chk("post rst state", {30'd0, dut.state}, {30'd0, ST_IDLE});
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k == 1) bus_rvalid = 1'b0;
         #1;
         chk($sformatf("late rvalid rdata %0d", k), rdata, 32'h0);
         chk($sformatf("late rvalid bus_valid %0d", k), {31'd0, bus_valid}, 32'd0);
         chk($sformatf("late rvalid state %0d", k), {30'd0, dut.state}, {30'd0, ST_IDLE});
      end
      @(negedge clk);

      access(vecs[14]);
      chk("recover done", {31'd0, o_done}, 32'd1);
      chk("recover rdata", o_rdata, 32'h12345678);
      chk("recover stall cycles", o_stall, 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
